// File: rtl/tcp_rx_pd_dispatch.sv
// -----------------------------------------------------------------------------
// tcp_rx_pd_dispatch
//
// Routes fixed-size descriptor cells (PDSZ beats of PDWID bits each) from the
// mix stage to either the MAC port or the TOE port, or discards them. The
// route is decoded from the 2-bit forward code in beat 0 and stays in force
// for the remaining beats of the cell. Each output has a one-entry register
// stage, so there is one cycle of latency and full throughput.
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   in_pd_vld/dat/rdy        cell-beat stream from the mix stage
//   mac_pd_vld/dat/rdy       MAC-bound cell stream
//   toe_pd_vld/dat/rdy       TOE-bound cell stream
//   mac/toe/drop_cell_cnt    completed cells per destination, 32-bit wrapping
//   dbg_sig                  {state[1:0], beat_cnt[3:0], 26'h0}
// -----------------------------------------------------------------------------
module tcp_rx_pd_dispatch #(
    parameter int         PDWID       = 128,
    parameter int         PDSZ        = 4,
    parameter int         FWD_LSB     = 0,
    parameter logic [1:0] VAL_FWD_MAC = 2'd1,
    parameter logic [1:0] VAL_FWD_TOE = 2'd2
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_pd_vld,
    input  logic [PDWID-1:0] in_pd_dat,
    output logic             in_pd_rdy,

    output logic             mac_pd_vld,
    output logic [PDWID-1:0] mac_pd_dat,
    input  logic             mac_pd_rdy,

    output logic             toe_pd_vld,
    output logic [PDWID-1:0] toe_pd_dat,
    input  logic             toe_pd_rdy,

    output logic [31:0]      mac_cell_cnt,
    output logic [31:0]      toe_cell_cnt,
    output logic [31:0]      drop_cell_cnt,
    output logic [31:0]      dbg_sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        TOE  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t     state;
    state_t     route;      // decoded from the current beat's forward code
    state_t     dest;       // destination of the beat now on the input
    logic [3:0] beat_cnt;
    logic       mac_en;
    logic       toe_en;
    logic       dest_rdy;
    logic       in_acc;
    logic       last_beat;
    logic       mac_load;
    logic       toe_load;

    // An output stage can take a new beat when it is empty or being drained.
    assign mac_en = !mac_pd_vld || mac_pd_rdy;
    assign toe_en = !toe_pd_vld || toe_pd_rdy;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        route    = DROP;
        dest     = state;
        dest_rdy = 1'b1;
        if (in_pd_dat[FWD_LSB+1:FWD_LSB] == VAL_FWD_MAC) begin
            route = MAC;
        end else if (in_pd_dat[FWD_LSB+1:FWD_LSB] == VAL_FWD_TOE) begin
            route = TOE;
        end
        // Beat 0 is steered by its own code; later beats follow the held state.
        if (state == IDLE) begin
            dest = route;
        end
        case (dest)
            MAC:     dest_rdy = mac_en;
            TOE:     dest_rdy = toe_en;
            default: dest_rdy = 1'b1;
        endcase
    end

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign in_pd_rdy = rst && dest_rdy;
    assign in_acc    = in_pd_vld && in_pd_rdy;
    assign last_beat = (beat_cnt == 4'(PDSZ - 1));
    assign mac_load  = in_acc && (dest == MAC);
    assign toe_load  = in_acc && (dest == TOE);

    // Cell framing: state leaves IDLE on beat 0 and returns on beat PDSZ-1,
    // so IDLE coincides exactly with beat_cnt == 0.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            beat_cnt <= 4'd0;
        end else if (in_acc) begin
            if (last_beat) begin
                state    <= IDLE;
                beat_cnt <= 4'd0;
            end else begin
                state    <= dest;
                beat_cnt <= beat_cnt + 4'd1;
            end
        end
    end

    // MAC output stage. Data is reset as well as valid so the port reads zero
    // while the block is held in reset.
    // NOTE: the data register is reset here because its reset value is
    // visible on the port; a pure storage array would normally be left unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_pd_vld <= 1'b0;
            mac_pd_dat <= '0;
        end else if (mac_load) begin
            mac_pd_vld <= 1'b1;
            mac_pd_dat <= in_pd_dat;
        end else if (mac_pd_rdy) begin
            mac_pd_vld <= 1'b0;
        end
    end

    // TOE output stage, identical in behaviour to the MAC stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            toe_pd_vld <= 1'b0;
            toe_pd_dat <= '0;
        end else if (toe_load) begin
            toe_pd_vld <= 1'b1;
            toe_pd_dat <= in_pd_dat;
        end else if (toe_pd_rdy) begin
            toe_pd_vld <= 1'b0;
        end
    end

    // Cell counters advance when the last beat of a cell is accepted and
    // wrap naturally at 32 bits. They are only written on an increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mac_cell_cnt  <= 32'd0;
            toe_cell_cnt  <= 32'd0;
            drop_cell_cnt <= 32'd0;
        end else if (in_acc && last_beat) begin
            case (dest)
                MAC:     mac_cell_cnt  <= mac_cell_cnt + 32'd1;
                TOE:     toe_cell_cnt  <= toe_cell_cnt + 32'd1;
                default: drop_cell_cnt <= drop_cell_cnt + 32'd1;
            endcase
        end
    end

    assign dbg_sig = {state, beat_cnt, 26'h0};

endmodule

// File: tb/tb_tcp_rx_pd_dispatch.sv
// -----------------------------------------------------------------------------
// tb_tcp_rx_pd_dispatch
//
// Directed and randomized stimulus for tcp_rx_pd_dispatch. A cell-level
// reference model decides each cell's destination from its forward code and
// appends its beats to a per-port expected queue; output monitors compare
// every delivered beat against the queue heads and check that a stalled
// output holds its data.
// -----------------------------------------------------------------------------
module tb_tcp_rx_pd_dispatch;

    localparam int PDWID = 128;
    localparam int PDSZ  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_pd_vld = 1'b0;
    logic [PDWID-1:0] in_pd_dat = '0;
    logic             in_pd_rdy;
    logic             mac_pd_vld;
    logic [PDWID-1:0] mac_pd_dat;
    logic             mac_pd_rdy = 1'b1;
    logic             toe_pd_vld;
    logic [PDWID-1:0] toe_pd_dat;
    logic             toe_pd_rdy = 1'b1;
    logic [31:0]      mac_cell_cnt;
    logic [31:0]      toe_cell_cnt;
    logic [31:0]      drop_cell_cnt;
    logic [31:0]      dbg_sig;

    tcp_rx_pd_dispatch #(
        .PDWID      (PDWID),
        .PDSZ       (PDSZ),
        .FWD_LSB    (0),
        .VAL_FWD_MAC(2'd1),
        .VAL_FWD_TOE(2'd2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_pd_vld    (in_pd_vld),
        .in_pd_dat    (in_pd_dat),
        .in_pd_rdy    (in_pd_rdy),
        .mac_pd_vld   (mac_pd_vld),
        .mac_pd_dat   (mac_pd_dat),
        .mac_pd_rdy   (mac_pd_rdy),
        .toe_pd_vld   (toe_pd_vld),
        .toe_pd_dat   (toe_pd_dat),
        .toe_pd_rdy   (toe_pd_rdy),
        .mac_cell_cnt (mac_cell_cnt),
        .toe_cell_cnt (toe_cell_cnt),
        .drop_cell_cnt(drop_cell_cnt),
        .dbg_sig      (dbg_sig)
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    int               stalls   = 0;
    bit               rand_rdy = 1'b0;

    // Reference model state.
    logic [PDWID-1:0] exp_mac_q[$];
    logic [PDWID-1:0] exp_toe_q[$];
    logic [31:0]      exp_mac_cnt  = 32'd0;
    logic [31:0]      exp_toe_cnt  = 32'd0;
    logic [31:0]      exp_drop_cnt = 32'd0;

    task automatic check(input string tag, input logic [PDWID-1:0] obs,
                         input logic [PDWID-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_mac_cnt"},  PDWID'(mac_cell_cnt),  PDWID'(exp_mac_cnt));
        check({tag, "_toe_cnt"},  PDWID'(toe_cell_cnt),  PDWID'(exp_toe_cnt));
        check({tag, "_drop_cnt"}, PDWID'(drop_cell_cnt), PDWID'(exp_drop_cnt));
    endtask

    // Advance to just after the next rising edge; optionally randomize rdy.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            mac_pd_rdy = ($urandom_range(0, 3) != 0);
            toe_pd_rdy = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Wait (bounded) until the beat on the input is accepted. Returns at the
    // falling edge preceding the accepting rising edge.
    task automatic wait_accept(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        @(negedge clk);
        while (!in_pd_rdy) begin
            stalls++;
            n++;
            if (n > 200) begin
                check("accept_timeout", PDWID'(in_pd_rdy), PDWID'(1));
                ok = 1'b0;
                return;
            end
            step();
            @(negedge clk);
        end
    endtask

    // Send nbeats of a cell with the given forward code. The model routes
    // the whole cell from the code: 1 -> MAC, 2 -> TOE, otherwise dropped.
    task automatic send_cell(input logic [1:0] code, input int nbeats,
                             input bit chk_lat, input bit gaps);
        logic [PDWID-1:0] beat;
        int               dest;
        int               g;
        bit               ok;
        dest = (code == 2'd1) ? 0 : ((code == 2'd2) ? 1 : 2);
        for (int b = 0; b < nbeats; b++) begin
            g = gaps ? $urandom_range(0, 2) : 0;
            repeat (g) begin
                in_pd_vld = 1'b0;
                step();
            end
            beat = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (b == 0) beat[1:0] = code;
            in_pd_vld = 1'b1;
            in_pd_dat = beat;
            wait_accept(ok);
            if (ok) begin
                if (dest == 0) exp_mac_q.push_back(beat);
                if (dest == 1) exp_toe_q.push_back(beat);
                if (b == PDSZ - 1) begin
                    if (dest == 0) exp_mac_cnt++;
                    else if (dest == 1) exp_toe_cnt++;
                    else exp_drop_cnt++;
                end
            end
            step();
            if (chk_lat && dest == 0) begin
                check("lat_mac_vld", PDWID'(mac_pd_vld), PDWID'(1));
                check("lat_mac_dat", mac_pd_dat, beat);
                check("lat_toe_idle", PDWID'(toe_pd_vld), PDWID'(0));
            end
        end
        in_pd_vld = 1'b0;
    endtask

    // Hold reset for one falling edge while offering a drop-coded beat, and
    // check the reset state there. The model forgets undelivered beats.
    task automatic do_reset();
        rst = 1'b0;
        exp_mac_q.delete();
        exp_toe_q.delete();
        exp_mac_cnt  = 32'd0;
        exp_toe_cnt  = 32'd0;
        exp_drop_cnt = 32'd0;
        in_pd_vld = 1'b1;
        in_pd_dat = '0;
        in_pd_dat[1:0] = 2'd3;
        @(negedge clk);
        check("rst_in_rdy",  PDWID'(in_pd_rdy),  PDWID'(0));
        check("rst_mac_vld", PDWID'(mac_pd_vld), PDWID'(0));
        check("rst_toe_vld", PDWID'(toe_pd_vld), PDWID'(0));
        check("rst_mac_dat", mac_pd_dat, '0);
        check("rst_toe_dat", toe_pd_dat, '0);
        check("rst_dbg",     PDWID'(dbg_sig),    PDWID'(0));
        check_cnts("rst");
        step();
        rst = 1'b1;
        in_pd_vld = 1'b0;
    endtask

    // Output monitors: sample at the falling edge, where vld/rdy/dat are the
    // values the next rising edge will act on.
    logic [PDWID-1:0] prev_mac_dat;
    logic [PDWID-1:0] prev_toe_dat;
    bit               prev_mac_hold = 1'b0;
    bit               prev_toe_hold = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (prev_mac_hold) begin
                check("mac_hold_vld", PDWID'(mac_pd_vld), PDWID'(1));
                check("mac_hold_dat", mac_pd_dat, prev_mac_dat);
            end
            if (mac_pd_vld && mac_pd_rdy) begin
                if (exp_mac_q.size() == 0) check("mac_extra_beat", PDWID'(mac_pd_vld), PDWID'(0));
                else check("mac_dat", mac_pd_dat, exp_mac_q.pop_front());
            end
            prev_mac_hold = mac_pd_vld && !mac_pd_rdy;
            prev_mac_dat  = mac_pd_dat;
        end else begin
            prev_mac_hold = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (prev_toe_hold) begin
                check("toe_hold_vld", PDWID'(toe_pd_vld), PDWID'(1));
                check("toe_hold_dat", toe_pd_dat, prev_toe_dat);
            end
            if (toe_pd_vld && toe_pd_rdy) begin
                if (exp_toe_q.size() == 0) check("toe_extra_beat", PDWID'(toe_pd_vld), PDWID'(0));
                else check("toe_dat", toe_pd_dat, exp_toe_q.pop_front());
            end
            prev_toe_hold = toe_pd_vld && !toe_pd_rdy;
            prev_toe_dat  = toe_pd_dat;
        end else begin
            prev_toe_hold = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        // Reset state.
        do_reset();

        // One MAC cell, all rdy=1: each beat appears one cycle after it is taken.
        send_cell(2'd1, PDSZ, 1'b1, 1'b0);
        check_cnts("mac_one");

        // Code-3 cell: accepted every cycle, nothing emitted, drop count bumps.
        stalls = 0;
        send_cell(2'd3, PDSZ, 1'b0, 1'b0);
        check("drop_stalls", PDWID'(stalls), PDWID'(0));
        check_cnts("drop_one");

        // Alternating TOE/MAC cells back-to-back at full rate.
        stalls = 0;
        for (int i = 0; i < 6; i++) send_cell((i % 2 == 0) ? 2'd2 : 2'd1, PDSZ, 1'b0, 1'b0);
        check("alt_stalls", PDWID'(stalls), PDWID'(0));
        check_cnts("alt");

        // MAC backpressure: first beat fills the register, then input stalls.
        mac_pd_rdy = 1'b0;
        fork
            send_cell(2'd1, PDSZ, 1'b0, 1'b0);
            begin
                repeat (2) @(negedge clk);
                for (int k = 0; k < 4; k++) begin
                    check("bp_in_rdy", PDWID'(in_pd_rdy), PDWID'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                mac_pd_rdy = 1'b1;
            end
        join
        check_cnts("bp");

        // A finished MAC cell stuck behind rdy=0 must not block a TOE cell.
        send_cell(2'd1, PDSZ, 1'b0, 1'b0);
        mac_pd_rdy = 1'b0;
        stalls = 0;
        send_cell(2'd2, PDSZ, 1'b0, 1'b0);
        check("indep_stalls", PDWID'(stalls), PDWID'(0));
        check("indep_mac_held", PDWID'(mac_pd_vld), PDWID'(1));
        mac_pd_rdy = 1'b1;
        step();
        check_cnts("indep");

        // Reset after beat 1 of a TOE cell; the next cell routes on its own beat 0.
        send_cell(2'd2, 2, 1'b0, 1'b0);
        check("partial_beat_cnt", PDWID'(dbg_sig[29:26]), PDWID'(2));
        do_reset();
        send_cell(2'd1, PDSZ, 1'b1, 1'b0);
        check_cnts("post_rst");

        // MAC counter wrap from all-ones.
        force dut.mac_cell_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.mac_cell_cnt;
        exp_mac_cnt = 32'hFFFF_FFFF;
        send_cell(2'd1, PDSZ, 1'b0, 1'b0);
        check("wrap_mac_cnt", PDWID'(mac_cell_cnt), PDWID'(0));

        // Randomized codes, input gaps and output backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) send_cell(2'($urandom_range(0, 3)), PDSZ, 1'b0, 1'b1);
        rand_rdy   = 1'b0;
        mac_pd_rdy = 1'b1;
        toe_pd_rdy = 1'b1;
        for (int i = 0; i < 50 && (exp_mac_q.size() + exp_toe_q.size()) != 0; i++) step();
        repeat (2) step();
        check("drain_mac_q", PDWID'(exp_mac_q.size()), PDWID'(0));
        check("drain_toe_q", PDWID'(exp_toe_q.size()), PDWID'(0));
        check_cnts("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
